// File: rtl/skullfet_pattern_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : skullfet_pattern_checker                                         |
// | Purpose : Drives four test vectors into the SkullFET inverter/NAND cells,  |
// |           samples their synchronized outputs and reports pass/fail.        |
// | Option  : define SKULLFET_FAIL_COUNT_EN to build the fail_count counter.   |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module skullfet_pattern_checker #(
    parameter int SETTLE = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       start,
    output logic       inverter_in,
    output logic       nand_in_a,
    output logic       nand_in_b,
    input  logic       inverter_out,
    input  logic       nand_out,
    output logic       busy,
    output logic [3:0] result,
    output logic [3:0] fail_vector,
    output logic [7:0] fail_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0] c_settle_load = 8'(SETTLE - 1);

    logic [1:0] r_state;
    logic [1:0] r_vec;
    logic [7:0] r_cnt;
    logic [1:0] r_sync_inv;
    logic [1:0] r_sync_nand;
    logic       r_done;
    logic       r_pass;
    logic       r_nand_err;
    logic       r_inv_err;
    logic [3:0] r_fail_vector;

    logic w_active;
    logic w_inv_mis;
    logic w_nand_mis;

    assign w_active    = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    assign busy        = w_active;
    assign nand_in_a   = w_active & r_vec[1];
    assign nand_in_b   = w_active & r_vec[0];
    assign inverter_in = w_active & r_vec[0];
    assign result      = {r_done, r_pass, r_nand_err, r_inv_err};
    assign fail_vector = r_fail_vector;

    // Only the second synchronizer stage is ever compared.
    assign w_inv_mis  = r_sync_inv[1]  != ~r_vec[0];
    assign w_nand_mis = r_sync_nand[1] != ~(r_vec[1] & r_vec[0]);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= S_IDLE;
            r_vec         <= 2'd0;
            r_cnt         <= 8'd0;
            r_sync_inv    <= 2'b00;
            r_sync_nand   <= 2'b00;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_nand_err    <= 1'b0;
            r_inv_err     <= 1'b0;
            r_fail_vector <= 4'd0;
        end else begin
            r_sync_inv  <= {r_sync_inv[0], inverter_out};
            r_sync_nand <= {r_sync_nand[0], nand_out};
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_DRIVE;
                        r_vec         <= 2'd0;
                        r_cnt         <= c_settle_load;
                        r_fail_vector <= 4'd0;
                        r_nand_err    <= 1'b0;
                        r_inv_err     <= 1'b0;
                        r_pass        <= 1'b0;
                        r_done        <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (w_inv_mis) begin
                        r_inv_err            <= 1'b1;
                        r_fail_vector[r_vec] <= 1'b1;
                    end
                    if (w_nand_mis) begin
                        r_nand_err           <= 1'b1;
                        r_fail_vector[r_vec] <= 1'b1;
                    end
                    if (r_vec == 2'd3) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        // Include this last sample's outcome, not yet in the error flags.
                        r_pass  <= ~(r_inv_err | r_nand_err | w_inv_mis | w_nand_mis);
                    end else begin
                        r_state <= S_DRIVE;
                        r_vec   <= r_vec + 2'd1;
                        r_cnt   <= c_settle_load;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SKULLFET_FAIL_COUNT_EN
    logic [7:0] r_fail_count;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_fail_count <= 8'd0;
        end else if ((r_state == S_SAMPLE) && (w_inv_mis || w_nand_mis) &&
                     (r_fail_count != 8'hFF)) begin
            r_fail_count <= r_fail_count + 8'd1;
        end
    end

    assign fail_count = r_fail_count;
`else
    assign fail_count = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_skullfet_pattern_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_skullfet_pattern_checker                                      |
// | Purpose : Scoreboard bench for skullfet_pattern_checker with cell models.  |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_skullfet_pattern_checker;

    localparam int SETTLE = 8;

    logic       clk;
    logic       rst;
    logic       start;
    logic       inverter_in;
    logic       nand_in_a;
    logic       nand_in_b;
    logic       inverter_out;
    logic       nand_out;
    logic       busy;
    logic [3:0] result;
    logic [3:0] fail_vector;
    logic [7:0] fail_count;

    logic r_inv_stuck0;
    logic r_nand_stuck1;

    int n_checks;
    int n_errors;
    int model_fc;

    typedef struct {
        logic [3:0] res;
        logic [3:0] fv;
        logic [7:0] fc;
        int         busy_cycles;
    } exp_t;

    exp_t exp_q[$];

    skullfet_pattern_checker #(.SETTLE(SETTLE)) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start       (start),
        .inverter_in (inverter_in),
        .nand_in_a   (nand_in_a),
        .nand_in_b   (nand_in_b),
        .inverter_out(inverter_out),
        .nand_out    (nand_out),
        .busy        (busy),
        .result      (result),
        .fail_vector (fail_vector),
        .fail_count  (fail_count)
    );

    assign inverter_out = r_inv_stuck0  ? 1'b0 : ~inverter_in;
    assign nand_out     = r_nand_stuck1 ? 1'b1 : ~(nand_in_a & nand_in_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_fc();
`ifdef SKULLFET_FAIL_COUNT_EN
        return 8'(model_fc);
`else
        return 8'h00;
`endif
    endfunction

    // Reference behaviour of one run against the current cell fault models.
    task automatic model_run(output logic [3:0] res, output logic [3:0] fv);
        logic inv_e, nand_e, a, b, inv_o, nand_o;
        int nfail;
        inv_e = 1'b0; nand_e = 1'b0; fv = 4'd0; nfail = 0;
        for (int v = 0; v < 4; v++) begin
            a      = (v >= 2);
            b      = (v % 2) == 1;
            inv_o  = r_inv_stuck0  ? 1'b0 : !b;
            nand_o = r_nand_stuck1 ? 1'b1 : !(a && b);
            if (inv_o != !b)         begin inv_e  = 1'b1; fv[v] = 1'b1; end
            if (nand_o != !(a && b)) begin nand_e = 1'b1; fv[v] = 1'b1; end
            if ((inv_o != !b) || (nand_o != !(a && b))) nfail++;
        end
        res = {1'b1, !(inv_e || nand_e), nand_e, inv_e};
        model_fc = (model_fc + nfail > 255) ? 255 : model_fc + nfail;
    endtask

    task automatic do_run(input string tag, input int repulse_at);
        exp_t e;
        exp_t got_e;
        int   cnt;
        model_run(e.res, e.fv);
        e.fc          = exp_fc();
        e.busy_cycles = 4 * (SETTLE + 1);
        exp_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 200) begin
            if (cnt == repulse_at)     start = 1'b1;
            if (cnt == repulse_at + 1) start = 1'b0;
            cnt++;
            tick();
        end
        start = 1'b0;
        got_e = exp_q.pop_front();
        check({tag, "_busy_cycles"}, cnt, got_e.busy_cycles);
        check({tag, "_result"}, {28'd0, result}, {28'd0, got_e.res});
        check({tag, "_fail_vector"}, {28'd0, fail_vector}, {28'd0, got_e.fv});
        check({tag, "_fail_count"}, {24'd0, fail_count}, {24'd0, got_e.fc});
        check({tag, "_drive_done"}, {29'd0, inverter_in, nand_in_a, nand_in_b}, 32'd0);
        tick();
    endtask

    initial begin
        n_checks = 0; n_errors = 0; model_fc = 0;
        rst = 1'b1; start = 1'b0;
        r_inv_stuck0 = 1'b0; r_nand_stuck1 = 1'b0;
        tick(); tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_result", {28'd0, result}, 32'd0);
        check("reset_fail_vector", {28'd0, fail_vector}, 32'd0);
        check("reset_fail_count", {24'd0, fail_count}, 32'd0);
        check("reset_drive", {29'd0, inverter_in, nand_in_a, nand_in_b}, 32'd0);
        rst = 1'b0;
        tick();

        do_run("ideal", -1);

        r_inv_stuck0 = 1'b1;
        do_run("inv_stuck0", -1);
        r_inv_stuck0 = 1'b0;

        r_nand_stuck1 = 1'b1;
        do_run("nand_stuck1", -1);
        r_nand_stuck1 = 1'b0;
        tick(); tick();
        check("held_result", {28'd0, result}, 32'hA);
        check("held_busy", {31'd0, busy}, 32'd0);

        do_run("repulse", 10);
        for (int i = 0; i < 5; i++) begin
            check("no_second_run", {31'd0, busy}, 32'd0);
            tick();
        end

        // Abort mid-run while vector 2 is being driven.
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int cnt;
            cnt = 0;
            while (!(nand_in_a && !nand_in_b) && cnt < 200) begin
                cnt++;
                tick();
            end
            check("reach_vector2", {31'd0, (nand_in_a && !nand_in_b)}, 32'd1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_fc = 0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", {28'd0, result}, 32'd0);
        check("abort_fail_vector", {28'd0, fail_vector}, 32'd0);
        check("abort_fail_count", {24'd0, fail_count}, 32'd0);
        check("abort_drive", {29'd0, inverter_in, nand_in_a, nand_in_b}, 32'd0);
        tick();
        do_run("after_abort", -1);

        r_inv_stuck0 = 1'b1;
        for (int r = 0; r < 130; r++) do_run("saturate", -1);
        r_inv_stuck0 = 1'b0;
        check("saturated_fail_count", {24'd0, fail_count}, {24'd0, exp_fc()});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skullfet_pattern_checker.md
SKULLFET_PATTERN_CHECKER -- requirements
Module: skullfet_pattern_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 8: cycles each vector is held before sampling; legal range 3..255.
REQ-002 SHALL have port wb_clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a test run; sampled only in IDLE.
REQ-005 SHALL have port inverter_in, output, 1: drive to the SkullFET inverter input (mprj_io[8]).
REQ-006 SHALL have port nand_in_a, output, 1: drive to the NAND A input (mprj_io[10]).
REQ-007 SHALL have port nand_in_b, output, 1: drive to the NAND B input (mprj_io[11]).
REQ-008 SHALL have port inverter_out, input, 1: inverter output (mprj_io[9]); asynchronous to wb_clk_i.
REQ-009 SHALL have port nand_out, input, 1: NAND output (mprj_io[12]); asynchronous to wb_clk_i.
REQ-010 SHALL have port busy, output, 1: high while a run is in progress.
REQ-011 SHALL have port result, output, 4: {done, pass, nand_err, inv_err}; feeds the management test-result nibble.
REQ-012 SHALL have port fail_vector, output, 4: bit v set if vector v failed in the last run.
REQ-013 SHALL have port fail_count, output, 8: saturating count of failing vector samples.

Function
REQ-014 SHALL implement states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 IDLE with start=1 SHALL move to DRIVE with vector index v=0 on the next cycle, clearing fail_vector, nand_err, inv_err, pass and done.
REQ-016 In DRIVE and SAMPLE, the outputs SHALL be nand_in_a=v[1], nand_in_b=v[0], inverter_in=v[0]; in IDLE and DONE all three SHALL be 0.
REQ-017 DRIVE SHALL last exactly SETTLE cycles, counted by a down-counter loaded with SETTLE-1, then go to SAMPLE.
REQ-018 inverter_out and nand_out SHALL each pass through a 2-flop synchronizer before any use.
REQ-019 SAMPLE SHALL last 1 cycle and compare the synchronized values against expected inverter = ~v[0] and expected nand = ~(v[1]&v[0]).
REQ-020 On an inverter mismatch in SAMPLE, the block SHALL set inv_err and fail_vector[v].
REQ-021 On a NAND mismatch in SAMPLE, the block SHALL set nand_err and fail_vector[v].
REQ-022 After SAMPLE, v<3 SHALL increment v and return to DRIVE; v=3 SHALL go to DONE.
REQ-023 A run SHALL take exactly 4*(SETTLE+1) cycles from the first DRIVE cycle to DONE entry.
REQ-024 In DONE, done=1 and pass=~(inv_err|nand_err); DONE SHALL go to IDLE next cycle with result held until the next accepted start.
REQ-025 busy SHALL be 1 in DRIVE and SAMPLE, and 0 otherwise.
REQ-026 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-027 fail_count SHALL increment by 1 per SAMPLE with any mismatch, saturate at 255, and be cleared only by reset.

Reset
REQ-028 wb_rst_i=1 SHALL force IDLE, v=0, drive outputs=0, busy=0, result=0, fail_vector=0, fail_count=0 and synchronizers=0 at the next edge.
REQ-029 Reset asserted mid-run SHALL abort the run with no done indication; the first start after release SHALL begin a fresh run at v=0.

Configuration
REQ-030 With macro SKULLFET_FAIL_COUNT_EN defined, the block SHALL implement the fail_count counter per REQ-027.
REQ-031 Without SKULLFET_FAIL_COUNT_EN, fail_count SHALL be tied to 8'h00 and no counter flops SHALL be inferred; all other behaviour SHALL be unchanged.

Verification
REQ-032 Ideal inverter/NAND models, SETTLE=8, pulse start -> busy for 36 cycles, then result=4'b1100 and fail_vector=0.
REQ-033 inverter_out stuck at 0 -> result=4'b1001, fail_vector=4'b0101, fail_count=2.
REQ-034 nand_out stuck at 1 -> result=4'b1010, fail_vector=4'b1000, fail_count=1.
REQ-035 start re-pulsed at cycle 10 of a run -> run still ends at cycle 36 and no second run starts.
REQ-036 wb_rst_i pulsed during vector 2 -> all outputs 0 next cycle; a new start completes with a clean pass.
REQ-037 With SKULLFET_FAIL_COUNT_EN defined and inverter stuck at 0 for 130 runs -> fail_count=255 (saturated); without the macro -> fail_count=0.
